sc_in_port: RTL and testbench
=============================

# sc_in_port

Memory-mapped input peripheral for the single-cycle computer: the input-side counterpart of the output port that drives the seven-segment display. It synchronises and debounces raw board switches/keys, latches rising edges into read-to-clear pending bits, and returns data to the CPU load path via a registered read interface. It sits beside `sc_datamem` in `sc_computer` and supplies the value the CPU reads as `in_port0`.

## Interface
- `WIDTH`, default 8: number of input bits (1–32).
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before the debounced value changes (≥2).
- Reset: one clock; reset is asynchronous and active-low.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `raw_in`  in  WIDTH  asynchronous switch/key levels.
- `rd_en`  in  1  read strobe, one cycle.
- `wr_en`  in  1  write strobe, one cycle; used only by the mask register.
- `addr`  in  2  register select: 0 DATA, 1 PENDING, 2 RAW, 3 MASK.
- `wdata`  in  32  write data; bits [WIDTH-1:0] used.
- `rdata`  out  32  registered read data, zero-extended above WIDTH.
- `rvalid`  out  1  high for exactly one cycle, the cycle after `rd_en`.
- `irq`  out  1  interrupt request, level.

## Operation
- Reset values: `rdata`=0, `rvalid`=0, `irq`=0; synchroniser flops, debounced value, counters, pending and mask all 0.
- Two-flop synchroniser per bit produces `sync`.
- Per-bit debounce, counter width `$clog2(DEBOUNCE_CYCLES)`:
  - `sync`==`deb`: counter <= 0.
  - `sync`!=`deb` and counter < DEBOUNCE_CYCLES-1: counter increments.
  - `sync`!=`deb` and counter == DEBOUNCE_CYCLES-1: `deb` <= `sync`, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the count. `deb` never changes.
- Pending: bit i is set on the same edge that `deb[i]` goes 0→1. It stays set until cleared.
- Reads: `rd_en` captures register `addr` into `rdata` and pulses `rvalid`. `rdata` holds its value until the next read.
  - Reading PENDING (addr 1) clears every pending bit that was returned.
  - If a bit is set and cleared on the same edge, the set wins, so no edge is lost.
- Writes to addr 3 load MASK (`IN_PORT_IRQ_EN` only). Writes to other addresses are ignored.
- `rd_en` and `wr_en` in the same cycle: both take effect. A read of MASK returns the old value.
- Back-to-back reads are allowed every cycle.

## Timing
- `raw_in` edge to `deb` update: 2 + DEBOUNCE_CYCLES cycles, provided the input stays stable.
- `deb` rise to pending set: same edge.
- Pending to `irq`: 1 cycle, because `irq` is registered.
- `rd_en` to `rdata`/`rvalid`: 1 cycle.
- Pending clear is visible in a PENDING read issued the next cycle.
- Reset asserted mid-debounce or with pending bits set: all state returns to reset values immediately. After release, stable-high inputs take 2 + DEBOUNCE_CYCLES cycles to reach `deb` and then set pending.

## Configuration
- `IN_PORT_IRQ_EN` defined:
  - MASK register is present.
  - `irq` <= |(pending & mask), registered.
- `IN_PORT_IRQ_EN` undefined:
  - No mask storage.
  - Reads of addr 3 return 0 and `wr_en` is ignored.
  - `irq` is tied to 0. The port list is unchanged.

## Structure
- Package `sc_in_port_pkg`:
  - address constants `IN_ADDR_DATA`/`PENDING`/`RAW`/`MASK` (0–3);
  - `IN_PORT_MAX_WIDTH`=32.
- Sub-module `sc_in_debounce`: one bit, containing the synchroniser, counter and `deb` output. It is instantiated WIDTH times with a generate loop.
- The top level holds pending, mask, read mux and `irq`.

## Test plan
All scenarios use WIDTH=8 and DEBOUNCE_CYCLES=4.
- Reset: hold `resetn`=0 with `raw_in`=8'hFF.
  - All outputs read 0 during reset.
  - After release, `deb` reaches 8'hFF at cycle 6.
  - A DATA read then returns 32'h000000FF.
- Glitch: drive `raw_in[0]` high for 3 cycles, then low.
  - DATA stays 0 and PENDING stays 0.
- Clean press: drive `raw_in[2]` high and hold.
  - After 6 cycles a PENDING read returns 32'h4.
  - A second read returns 0.
  - DATA still returns 32'h4.
- Set/clear collision: time a PENDING read on the same edge that `deb[5]` rises.
  - The returned value lacks bit 5.
  - The next PENDING read returns 32'h20.
- Read interface: issue reads on consecutive cycles at addr 0, 2 and 3.
  - `rvalid` is high for 3 consecutive cycles, each one cycle after its `rd_en`.
  - Addr 3 returns 0 when `IN_PORT_IRQ_EN` is undefined.
- IRQ (`IN_PORT_IRQ_EN` defined):
  - Write MASK=8'h01, then press bit 1: `irq` stays 0.
  - Press bit 0: `irq`=1 one cycle after pending sets.
  - A PENDING read drops `irq` within 2 cycles.

Source files
------------

// File: rtl/sc_in_port_pkg.sv
// sc_in_port shared definitions: register map and width limits.
// Optional IRQ/MASK support is enabled with IN_PORT_IRQ_EN.
package sc_in_port_pkg;

  localparam int IN_PORT_MAX_WIDTH = 32;

  localparam logic [1:0] IN_ADDR_DATA    = 2'd0;
  localparam logic [1:0] IN_ADDR_PENDING = 2'd1;
  localparam logic [1:0] IN_ADDR_RAW     = 2'd2;
  localparam logic [1:0] IN_ADDR_MASK    = 2'd3;

endpackage

// File: rtl/sc_in_debounce.sv
// One-bit input conditioner: two-flop synchroniser plus
// stable-count debounce; rise flags the edge deb goes 0->1.
module sc_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic sync,
  output logic deb,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          deb_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b0;
      sync <= 1'b0;
      deb  <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      deb  <= deb_d;
      cnt  <= cnt_d;
    end
  end

  always_comb begin
    deb_d = deb;
    cnt_d = cnt;
    if (sync == deb) begin
      cnt_d = '0;
    end else if (cnt == CNT_MAX) begin
      deb_d = sync;
      cnt_d = '0;
    end else begin
      cnt_d = cnt + CW'(1);
    end
  end

  assign rise = deb_d & ~deb;

endmodule

// File: rtl/sc_in_port.sv
// Memory-mapped debounced input port with read-to-clear pending bits.
// Define IN_PORT_IRQ_EN to add the MASK register and a live irq.
module sc_in_port
  import sc_in_port_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             rvalid,
  output logic             irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_d;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask_rd;
  logic [WIDTH-1:0] sel;
  logic [31:0]      rdata_d;
  logic             unused_ok;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sc_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock (clock),
      .resetn(resetn),
      .raw   (raw_in[i]),
      .sync  (sync[i]),
      .deb   (deb[i]),
      .rise  (rise[i])
    );
  end

  // Set beats clear so an edge landing on a read is not lost.
  always_comb begin
    clr = '0;
    if (rd_en && addr == IN_ADDR_PENDING) clr = pending;
    pending_d = (pending & ~clr) | rise;
  end

  always_comb begin
    sel = '0;
    unique case (1'b1)
      (addr == IN_ADDR_DATA):    sel = deb;
      (addr == IN_ADDR_PENDING): sel = pending;
      (addr == IN_ADDR_RAW):     sel = sync;
      (addr == IN_ADDR_MASK):    sel = mask_rd;
      default:                   sel = '0;
    endcase
    rdata_d = '0;
    rdata_d[WIDTH-1:0] = sel;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
    end else begin
      pending <= pending_d;
      rvalid  <= rd_en;
      if (rd_en) rdata <= rdata_d;
    end
  end

`ifdef IN_PORT_IRQ_EN
  logic [WIDTH-1:0] mask;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_en && addr == IN_ADDR_MASK) mask <= wdata[WIDTH-1:0];
      irq <= |(pending & mask);
    end
  end

  assign mask_rd = mask;
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  assign unused_ok = ^{wr_en, wdata};

endmodule

// File: tb/tb_sc_in_port.sv
// Directed bench for sc_in_port, WIDTH=8, DEBOUNCE_CYCLES=4.
// Build with +define+IN_PORT_IRQ_EN to exercise the mask/irq path.
module tb_sc_in_port;
  import sc_in_port_pkg::*;

  logic        clock;
  logic        resetn;
  logic [7:0]  raw_in;
  logic        rd_en;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int total;
  int bad;

  sc_in_port #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .raw_in(raw_in),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .rvalid(rvalid),
    .irq   (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    raw_in = 8'hFF;
    rd_en  = 1'b1;
    addr   = IN_ADDR_DATA;
    tick(3);
    total++;
    if (rdata !== 32'h0 || rvalid !== 1'b0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs rdata=%h rvalid=%b irq=%b want 0/0/0",
               rdata, rvalid, irq);
    end
    rd_en  = 1'b0;
    resetn = 1'b1;
    tick(5);
    rd(IN_ADDR_DATA);
    total++;
    if (rdata !== 32'h0 || rvalid !== 1'b1) begin
      bad++;
      $display("FAIL reset_deb_early rdata=%h rvalid=%b want 0/1",
               rdata, rvalid);
    end
    rd(IN_ADDR_DATA);
    total++;
    if (rdata !== 32'h000000FF) begin
      bad++;
      $display("FAIL reset_deb_cycle6 rdata=%h want 000000ff", rdata);
    end
    rd(IN_ADDR_PENDING);
    total++;
    if (rdata !== 32'hFF) begin
      bad++;
      $display("FAIL reset_pending rdata=%h want ff", rdata);
    end
    raw_in = 8'h00;
    tick(10);
    rd(IN_ADDR_PENDING);
    total++;
    if (rdata !== 32'h0) begin
      bad++;
      $display("FAIL fall_no_pending rdata=%h want 0", rdata);
    end
    rd(IN_ADDR_DATA);
    total++;
    if (rdata !== 32'h0) begin
      bad++;
      $display("FAIL fall_data rdata=%h want 0", rdata);
    end
  endtask

  task automatic test_glitch;
    raw_in[0] = 1'b1;
    tick(3);
    raw_in[0] = 1'b0;
    tick(10);
    rd(IN_ADDR_DATA);
    total++;
    if (rdata !== 32'h0) begin
      bad++;
      $display("FAIL glitch_data rdata=%h want 0", rdata);
    end
    rd(IN_ADDR_PENDING);
    total++;
    if (rdata !== 32'h0) begin
      bad++;
      $display("FAIL glitch_pending rdata=%h want 0", rdata);
    end
  endtask

  task automatic test_press;
    raw_in[2] = 1'b1;
    tick(6);
    rd(IN_ADDR_PENDING);
    total++;
    if (rdata !== 32'h4) begin
      bad++;
      $display("FAIL press_pending rdata=%h want 4", rdata);
    end
    rd(IN_ADDR_PENDING);
    total++;
    if (rdata !== 32'h0) begin
      bad++;
      $display("FAIL press_cleared rdata=%h want 0", rdata);
    end
    rd(IN_ADDR_DATA);
    total++;
    if (rdata !== 32'h4) begin
      bad++;
      $display("FAIL press_data rdata=%h want 4", rdata);
    end
  endtask

  task automatic test_collision;
    raw_in[5] = 1'b1;
    tick(5);
    rd(IN_ADDR_PENDING);
    total++;
    if (rdata !== 32'h0) begin
      bad++;
      $display("FAIL collide_first rdata=%h want 0", rdata);
    end
    rd(IN_ADDR_PENDING);
    total++;
    if (rdata !== 32'h20) begin
      bad++;
      $display("FAIL collide_kept rdata=%h want 20", rdata);
    end
    rd(IN_ADDR_PENDING);
    total++;
    if (rdata !== 32'h0) begin
      bad++;
      $display("FAIL collide_cleared rdata=%h want 0", rdata);
    end
  endtask

  task automatic test_back_to_back;
    tick();
    total++;
    if (rvalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle rvalid=%b want 0", rvalid);
    end
    rd_en = 1'b1;
    addr  = IN_ADDR_DATA;
    tick();
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'h24) begin
      bad++;
      $display("FAIL b2b_data rvalid=%b rdata=%h want 1/24", rvalid, rdata);
    end
    addr = IN_ADDR_RAW;
    tick();
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'h24) begin
      bad++;
      $display("FAIL b2b_raw rvalid=%b rdata=%h want 1/24", rvalid, rdata);
    end
    addr = IN_ADDR_MASK;
    tick();
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL b2b_mask rvalid=%b rdata=%h want 1/0", rvalid, rdata);
    end
    rd_en = 1'b0;
    tick();
    total++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL b2b_hold rvalid=%b rdata=%h want 0/0", rvalid, rdata);
    end
  endtask

  task automatic test_mask;
    logic [31:0] exp_mask;
`ifdef IN_PORT_IRQ_EN
    exp_mask = 32'h01;
`else
    exp_mask = 32'h00;
`endif
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr  = IN_ADDR_MASK;
    wdata = 32'hFFFF_FF01;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    total++;
    if (rdata !== 32'h0) begin
      bad++;
      $display("FAIL mask_rw_old rdata=%h want 0", rdata);
    end
    rd(IN_ADDR_MASK);
    total++;
    if (rdata !== exp_mask) begin
      bad++;
      $display("FAIL mask_read rdata=%h want %h", rdata, exp_mask);
    end
    wr_en = 1'b1;
    addr  = IN_ADDR_DATA;
    wdata = 32'hFF;
    tick();
    wr_en = 1'b0;
    rd(IN_ADDR_MASK);
    total++;
    if (rdata !== exp_mask) begin
      bad++;
      $display("FAIL mask_other_addr rdata=%h want %h", rdata, exp_mask);
    end
  endtask

  task automatic test_irq;
    logic exp_irq;
`ifdef IN_PORT_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    raw_in[1] = 1'b1;
    tick(8);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_masked irq=%b want 0", irq);
    end
    raw_in[0] = 1'b1;
    tick(6);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_same_edge irq=%b want 0", irq);
    end
    tick();
    total++;
    if (irq !== exp_irq) begin
      bad++;
      $display("FAIL irq_raise irq=%b want %b", irq, exp_irq);
    end
    rd(IN_ADDR_PENDING);
    total++;
    if (rdata !== 32'h3) begin
      bad++;
      $display("FAIL irq_pending rdata=%h want 3", rdata);
    end
    tick();
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_drop irq=%b want 0", irq);
    end
  endtask

  task automatic test_reset_mid;
    raw_in[7] = 1'b1;
    tick(3);
    rd(IN_ADDR_DATA);
    resetn = 1'b0;
    #1;
    total++;
    if (rdata !== 32'h0 || rvalid !== 1'b0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs rdata=%h rvalid=%b irq=%b want 0/0/0",
               rdata, rvalid, irq);
    end
    tick(2);
    resetn = 1'b1;
    tick(5);
    rd(IN_ADDR_PENDING);
    total++;
    if (rdata !== 32'h0) begin
      bad++;
      $display("FAIL midreset_early rdata=%h want 0", rdata);
    end
    rd(IN_ADDR_PENDING);
    total++;
    if (rdata !== 32'hA7) begin
      bad++;
      $display("FAIL midreset_pending rdata=%h want a7", rdata);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b0;
    raw_in = '0;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    addr   = '0;
    wdata  = '0;
    test_reset();
    test_glitch();
    test_press();
    test_collision();
    test_back_to_back();
    test_mask();
    test_irq();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
